ysyx_25060170_ifu: RTL and testbench
====================================

Name: ysyx_25060170_ifu

Overview:
- Instruction fetch unit for the multi-cycle NPC core.
- Owns the PC and fetches one instruction at a time from instruction memory over a valid/ready request/response handshake.
- Hands the instruction to the IDU and then waits for the execute-side completion.
- On completion, takes the jump target/enable produced by the EXU as the next PC; otherwise it advances PC by 4.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
ADDR_W, 32, PC/address width

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_W  fetch address (= pc)
imem_rsp_valid  input  1  fetch data valid
imem_rsp_data  input  32  fetched instruction
imem_rsp_ready  output  1  IFU accepts response
inst_valid  output  1  instruction valid to IDU
inst_ready  input  1  IDU accepts instruction
inst  output  32  instruction to IDU
pc  output  ADDR_W  PC of current instruction
exec_done  input  1  one-cycle pulse: current instruction finished execute/writeback
jump_en  input  1  qualifies jump_addr, sampled only with exec_done
jump_addr  input  ADDR_W  jump/branch target from EXU
misalign_err  output  1  one-cycle pulse: jump_addr[1:0] != 0 on redirect

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=REQ.
  - imem_req_valid=0, imem_rsp_ready=0, inst_valid=0, inst=0, misalign_err=0.
  - Deasserting rst_n starts REQ on the next edge; no request is issued while in reset.
- States and transitions:
  - REQ: imem_req_valid=1, imem_req_addr=pc. On req_valid&req_ready -> WAIT. The address must stay stable while waiting.
  - WAIT: imem_rsp_ready=1. On rsp_valid, latch inst<=rsp_data -> HOLD. A response is never accepted in the same cycle as its request.
  - HOLD: inst_valid=1, inst stable. On inst_valid&inst_ready -> EXEC, and inst_valid drops the next cycle.
  - EXEC: waits for exec_done.
    - On exec_done with jump_en=1: pc<=jump_addr with bits [1:0] forced to 0; misalign_err pulses the next cycle if jump_addr[1:0]!=0.
    - On exec_done with jump_en=0: pc<=pc+4, 32-bit wrap (0xFFFF_FFFC -> 0x0000_0000).
    - Then -> REQ.
- Latency:
  - With zero-wait memory and IDU, the minimum gap from req accepted to next req_valid is 4 cycles (WAIT, HOLD, EXEC-done, REQ).
  - With exec_done arriving in the first EXEC cycle, the next request appears one cycle after exec_done.
- Ignored inputs:
  - exec_done outside EXEC is ignored (no PC change).
  - jump_en/jump_addr are don't-care without exec_done.
  - rsp_valid outside WAIT is ignored and not latched.
- pc stays constant from REQ through EXEC, so it is the PC of the instruction being executed.
- Reset mid-operation: any state returns to reset values immediately. An outstanding memory response arriving after reset, while in REQ, is dropped.
- inst holds its last value outside HOLD; only inst_valid qualifies it.

Test Plan:
- Reset then zero-wait memory returning 0x00000413:
  - req_addr=0x80000000 the first cycle after reset release.
  - inst=0x00000413 with inst_valid.
  - After exec_done with jump_en=0, next req_addr=0x80000004.
- Backpressure:
  - Hold req_ready=0 for 3 cycles: req_valid and req_addr=0x80000000 stay stable, then accepted.
  - Hold inst_ready=0 for 5 cycles: inst_valid and inst stay stable.
- Jump:
  - exec_done with jump_en=1, jump_addr=0x80000100 -> pc=0x80000100, next req_addr=0x80000100, misalign_err=0.
- Misaligned jump:
  - jump_addr=0x80000102 -> pc=0x80000100 and a one-cycle misalign_err pulse.
  - jump_addr=0x80000103 -> same response.
- Spurious inputs:
  - exec_done pulse during WAIT -> pc unchanged.
  - rsp_valid during REQ -> inst not updated, state unchanged.
- Wrap and reset mid-operation:
  - pc=0xFFFFFFFC with sequential completion -> pc=0x00000000.
  - rst_n low during HOLD -> inst_valid=0 and pc=0x80000000 in the same cycle.

Source files
------------

// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction per round trip
// over a valid/ready memory interface, hands it to the IDU and waits for execute.
module ysyx_25060170_ifu #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              imem_rsp_ready,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  input  logic              exec_done,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              misalign_err
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, EXEC} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;
  logic                req_valid_q, req_valid_d;
  logic                rsp_ready_q, rsp_ready_d;
  logic                inst_valid_q, inst_valid_d;
  logic                misalign_q, misalign_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      req_valid_q  <= 1'b0;
      rsp_ready_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      req_valid_q  <= req_valid_d;
      rsp_ready_q  <= rsp_ready_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    misalign_d = 1'b0;
    unique case (state_q)
      // req_valid_q is low only in the first cycle out of reset, so no
      // request can be accepted while reset is still being released.
      REQ:  if (req_valid_q && imem_req_ready) state_d = WAIT;
      WAIT: if (imem_rsp_valid) begin
              inst_d  = imem_rsp_data;
              state_d = HOLD;
            end
      HOLD: if (inst_ready) state_d = EXEC;
      EXEC: if (exec_done) begin
              if (jump_en) begin
                pc_d       = {jump_addr[ADDR_W-1:2], 2'b00};
                misalign_d = |jump_addr[1:0];
              end else begin
                pc_d = pc_q + ADDR_W'(4);
              end
              state_d = REQ;
            end
      default: state_d = REQ;
    endcase
    // Handshake outputs are registered off the next state.
    req_valid_d  = (state_d == REQ);
    rsp_ready_d  = (state_d == WAIT);
    inst_valid_d = (state_d == HOLD);
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign imem_rsp_ready = rsp_ready_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Self-checking bench for the IFU: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a transaction-level model.
module tb_ysyx_25060170_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, pc;
  logic        exec_done, jump_en;
  logic [31:0] jump_addr;
  logic        misalign_err;

  ysyx_25060170_ifu #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_ready(imem_rsp_ready),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .exec_done(exec_done), .jump_en(jump_en), .jump_addr(jump_addr),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: which phase of the fetch round trip we are in, plus the
  // architectural PC, the last latched instruction and the error pulse.
  int          m_ph;     // 0 request, 1 waiting for data, 2 offered to IDU, 3 executing
  bit          m_live;   // false only in the first cycle after reset release
  logic [31:0] m_pc, m_inst;
  bit          m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_live = 0; m_pc = RST_PC; m_inst = 0; m_mis = 0;
  endtask

  task automatic model_edge();
    bit mis_n = 0;
    case (m_ph)
      0: if (m_live && imem_req_ready) m_ph = 1;
      1: if (imem_rsp_valid) begin m_inst = imem_rsp_data; m_ph = 2; end
      2: if (inst_ready) m_ph = 3;
      default: if (exec_done) begin
        if (jump_en) begin
          mis_n = (jump_addr[1:0] != 2'b00);
          m_pc  = jump_addr & 32'hFFFF_FFFC;
        end else m_pc = m_pc + 32'd4;
        m_ph = 0;
      end
    endcase
    m_mis  = mis_n;
    m_live = 1;
  endtask

  task automatic compare();
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, m_live && m_ph == 0});
    chk("req_addr",  imem_req_addr, m_pc);
    chk("rsp_ready", {31'b0, imem_rsp_ready}, {31'b0, m_ph == 1});
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_ph == 2});
    chk("inst", inst, m_inst);
    chk("pc", pc, m_pc);
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
  endtask

  // One clock: drive inputs (we are just past a negedge), model the edge, check.
  task automatic cyc(input bit rr, input bit rv, input logic [31:0] rd,
                     input bit ir, input bit ed, input bit je, input logic [31:0] ja);
    imem_req_ready = rr; imem_rsp_valid = rv; imem_rsp_data = rd;
    inst_ready = ir; exec_done = ed; jump_en = je; jump_addr = ja;
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    cyc(0, 0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  // From REQ with req_valid up: accept request, return data, IDU takes it.
  task automatic fetch(input logic [31:0] d);
    cyc(1, 0, 32'h0, 0, 0, 0, 32'h0);
    cyc(0, 1, d, 0, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 1, 0, 0, 32'h0);
  endtask

  task automatic exec(input bit je, input logic [31:0] ja);
    cyc(0, 0, 32'h0, 0, 1, je, ja);
  endtask

  initial begin
    rst_n = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    inst_ready = 0; exec_done = 0; jump_en = 0; jump_addr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst pc", pc, 32'h8000_0000);
    chk("rst inst", inst, 32'h0);
    compare();
    rst_n = 1;

    // Basic fetch with backpressure on request and on IDU.
    idle();
    chk("first req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first req_addr", imem_req_addr, 32'h8000_0000);
    repeat (3) begin
      idle();
      chk("bp req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("bp req_addr", imem_req_addr, 32'h8000_0000);
    end
    cyc(1, 0, 32'h0, 0, 0, 0, 32'h0);
    cyc(0, 1, 32'h0000_0413, 0, 0, 0, 32'h0);
    chk("inst latched", inst, 32'h0000_0413);
    repeat (5) begin
      idle();
      chk("bp inst_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp inst", inst, 32'h0000_0413);
    end
    cyc(0, 0, 32'h0, 1, 0, 0, 32'h0);
    chk("exec inst_valid low", {31'b0, inst_valid}, 32'd0);
    exec(0, 32'h0);
    chk("seq next addr", imem_req_addr, 32'h8000_0004);
    chk("seq next req_valid", {31'b0, imem_req_valid}, 32'd1);

    // Aligned and misaligned jumps.
    fetch(32'h1111_1111); exec(1, 32'h8000_0100);
    chk("jump pc", pc, 32'h8000_0100);
    chk("jump no err", {31'b0, misalign_err}, 32'd0);
    fetch(32'h2222_2222); exec(1, 32'h8000_0102);
    chk("mis2 pc", pc, 32'h8000_0100);
    chk("mis2 err", {31'b0, misalign_err}, 32'd1);
    cyc(1, 0, 32'h0, 0, 0, 0, 32'h0);
    chk("mis2 err drop", {31'b0, misalign_err}, 32'd0);
    cyc(0, 1, 32'h3, 0, 0, 0, 32'h0); cyc(0, 0, 32'h0, 1, 0, 0, 32'h0);
    exec(1, 32'h8000_0103);
    chk("mis3 pc", pc, 32'h8000_0100);
    chk("mis3 err", {31'b0, misalign_err}, 32'd1);

    // Spurious exec_done in WAIT, spurious response in REQ.
    cyc(1, 0, 32'h0, 0, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 0, 1, 1, 32'h1234_5678);
    chk("spur exec pc", pc, 32'h8000_0100);
    cyc(0, 1, 32'hAAAA_5555, 0, 0, 0, 32'h0); cyc(0, 0, 32'h0, 1, 0, 0, 32'h0);
    exec(0, 32'h0);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0);
    chk("spur rsp inst", inst, 32'hAAAA_5555);
    chk("spur rsp req_valid", {31'b0, imem_req_valid}, 32'd1);

    // PC wrap.
    fetch(32'h4); exec(1, 32'hFFFF_FFFC);
    fetch(32'h5); exec(0, 32'h0);
    chk("wrap pc", pc, 32'h0000_0000);

    // Reset during HOLD takes effect immediately.
    cyc(1, 0, 32'h0, 0, 0, 0, 32'h0);
    cyc(0, 1, 32'h6, 0, 0, 0, 32'h0);
    #2 rst_n = 0;
    #1;
    chk("midrst inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("midrst pc", pc, 32'h8000_0000);
    model_reset();
    @(negedge clk);
    compare();
    rst_n = 1;
    // Stale response arriving in REQ after reset is dropped.
    cyc(0, 1, 32'h7777_7777, 0, 0, 0, 32'h0);
    chk("stale rsp inst", inst, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ja;
      ja = $urandom;
      if ($urandom_range(0, 1) == 0) ja[1:0] = 2'b00;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom,
          $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1, ja);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
